// File: rtl/frac_clk_gen.sv
// Fractional clock generator: a phase accumulator whose MSB is the output clock.
// Increment changes and stops are deferred to a carry so clk_out periods are never split.
module frac_clk_gen #(
  parameter int unsigned ACC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [ACC_W-1:0] cfg_inc,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic [15:0]      period_cnt
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   inc_q, inc_d;
  logic [ACC_W-1:0]   pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic               tick_q, tick_d;
  logic               cfg_err_q, cfg_err_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               busy_q, busy_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [ACC_W:0]     sum_c;
  logic               carry_c;
  logic               xfer_c;
  logic               legal_c;
  logic               accept_c;

  // Phase addition and config legality (1 .. 2^(ACC_W-1))
  always_comb begin
    sum_c    = {1'b0, acc_q} + {1'b0, inc_q};
    carry_c  = sum_c[ACC_W];
    xfer_c   = cfg_valid & cfg_ready_q;
    legal_c  = (cfg_inc != '0) &&
               (!cfg_inc[ACC_W-1] || (cfg_inc[ACC_W-2:0] == '0));
    accept_c = xfer_c & legal_c;
  end

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    inc_d      = inc_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    tick_d     = 1'b0;
    cfg_err_d  = xfer_c & ~legal_c;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        acc_d = '0;
        if (accept_c) begin
          inc_d = cfg_inc;
        end
        if (en && (inc_q != '0)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end

      RUN: begin
        acc_d = sum_c[ACC_W-1:0];
        if (carry_c) begin
          tick_d = 1'b1;
          cnt_d  = cnt_q + CNT_W'(1);
        end
        // A carry in the acceptance cycle still completes with the old increment
        if (accept_c) begin
          pend_d     = cfg_inc;
          pend_vld_d = 1'b1;
          state_d    = en ? PEND : STOP;
        end else if (!en) begin
          state_d = STOP;
        end
      end

      PEND: begin
        acc_d = sum_c[ACC_W-1:0];
        if (carry_c) begin
          tick_d     = 1'b1;
          cnt_d      = cnt_q + CNT_W'(1);
          inc_d      = pend_q;
          pend_vld_d = 1'b0;
          state_d    = en ? RUN : STOP;
        end else if (!en) begin
          state_d = STOP;
        end
      end

      STOP: begin
        acc_d = sum_c[ACC_W-1:0];
        if (carry_c) begin
          tick_d  = 1'b1;
          cnt_d   = cnt_q + CNT_W'(1);
          acc_d   = '0;
          state_d = IDLE;
          if (pend_vld_q) begin
            inc_d      = pend_q;
            pend_vld_d = 1'b0;
          end
        end
      end

      default: begin
        state_d = IDLE;
        acc_d   = '0;
      end
    endcase

    busy_d      = (state_d != IDLE);
    cfg_ready_d = (state_d == IDLE) || (state_d == RUN);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      inc_q       <= '0;
      pend_q      <= '0;
      pend_vld_q  <= 1'b0;
      tick_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      inc_q       <= inc_d;
      pend_q      <= pend_d;
      pend_vld_q  <= pend_vld_d;
      tick_q      <= tick_d;
      cfg_err_q   <= cfg_err_d;
      cfg_ready_q <= cfg_ready_d;
      busy_q      <= busy_d;
      cnt_q       <= cnt_d;
    end
  end

  assign clk_out    = acc_q[ACC_W-1];
  assign tick       = tick_q;
  assign cfg_err    = cfg_err_q;
  assign cfg_ready  = cfg_ready_q;
  assign busy       = busy_q;
  assign period_cnt = cnt_q;

endmodule

// File: tb/tb_frac_clk_gen.sv
// Bench for frac_clk_gen (ACC_W=8): expected tick intervals are queued as stimulus
// is applied and popped as ticks appear.
module tb_frac_clk_gen;

  localparam int unsigned ACC_W = 8;

  logic             clk;
  logic             rst;
  logic             en;
  logic             cfg_valid;
  logic [ACC_W-1:0] cfg_inc;
  logic             cfg_ready;
  logic             cfg_err;
  logic             clk_out;
  logic             tick;
  logic             busy;
  logic [15:0]      period_cnt;

  int vecs;
  int errs;
  int cyc;
  int last_tick;
  int ntick;
  int highs;
  int exp_q[$];

  frac_clk_gen #(.ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_inc    (cfg_inc),
    .cfg_ready  (cfg_ready),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .busy       (busy),
    .period_cnt (period_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: outputs sampled and inputs driven 1ns after the rising edge
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Advance n cycles, scoring every tick against the queued interval
  task automatic run_cycles(input int n);
    int exp_iv;
    for (int i = 0; i < n; i++) begin
      step();
      if (clk_out === 1'b1) highs++;
      if (tick === 1'b1) begin
        ntick++;
        vecs++;
        if (exp_q.size() == 0) begin
          errs++;
          $display("FAIL tick_unexpected: tick at cycle %0d, required none", cyc);
        end else begin
          exp_iv = exp_q.pop_front();
          if ((cyc - last_tick) !== exp_iv) begin
            errs++;
            $display("FAIL tick_interval: got %0d, required %0d (cycle %0d)",
                     cyc - last_tick, exp_iv, cyc);
          end
        end
        last_tick = cyc;
      end
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    en        = 1'b0;
    cfg_valid = 1'b0;
    cfg_inc   = '0;
    step();
    step();
    rst = 1'b0;
    exp_q.delete();
    ntick = 0;
    highs = 0;
  endtask

  task automatic load(input logic [ACC_W-1:0] v);
    cfg_valid = 1'b1;
    cfg_inc   = v;
    step();
    cfg_valid = 1'b0;
    vecs++;
    if (cfg_err !== 1'b0) begin
      errs++;
      $display("FAIL load_err: cfg_err=%0b, required 0 for inc %0d", cfg_err, v);
    end
  endtask

  task automatic start_run();
    en = 1'b1;
    step();
    last_tick = cyc;
    ntick = 0;
    highs = 0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; cfg_valid = 1'b1; cfg_inc = 8'd64;
    step();
    step();
    vecs++;
    if ({busy, clk_out, tick, cfg_err, cfg_ready} !== 5'b00001 || period_cnt !== 16'd0) begin
      errs++;
      $display("FAIL reset_outputs: busy/clk_out/tick/err/ready=%b cnt=%0d, required 00001 cnt=0",
               {busy, clk_out, tick, cfg_err, cfg_ready}, period_cnt);
    end
    rst = 1'b0; cfg_valid = 1'b0; en = 1'b1;
    step();
    step();
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL reset_inc_zero: busy=%0b, required 0", busy);
    end
  endtask

  task automatic test_inc64();
    do_reset();
    load(8'd64);
    start_run();
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL inc64_busy: busy=%0b, required 1", busy);
    end
    for (int i = 0; i < 5; i++) exp_q.push_back(4);
    run_cycles(20);
    vecs++;
    if (ntick !== 5 || period_cnt !== 16'd5) begin
      errs++;
      $display("FAIL inc64_count: ticks=%0d cnt=%0d, required 5 and 5", ntick, period_cnt);
    end
    vecs++;
    if (highs !== 10) begin
      errs++;
      $display("FAIL inc64_duty: clk_out high %0d of 20, required 10", highs);
    end
    en = 1'b0;
  endtask

  task automatic test_inc96();
    do_reset();
    load(8'd96);
    start_run();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(3);
      exp_q.push_back(3);
      exp_q.push_back(2);
    end
    run_cycles(64);
    vecs++;
    if (ntick !== 24 || period_cnt !== 16'd24 || exp_q.size() != 0) begin
      errs++;
      $display("FAIL inc96_count: ticks=%0d cnt=%0d left=%0d, required 24 24 0",
               ntick, period_cnt, exp_q.size());
    end
    en = 1'b0;
  endtask

  task automatic test_illegal();
    logic [ACC_W-1:0] bad [2];
    bad[0] = 8'd0;
    bad[1] = 8'd129;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      cfg_valid = 1'b1;
      cfg_inc   = bad[k];
      step();
      cfg_valid = 1'b0;
      vecs++;
      if (cfg_err !== 1'b1) begin
        errs++;
        $display("FAIL illegal_err_pulse: inc %0d cfg_err=%0b, required 1", bad[k], cfg_err);
      end
      step();
      vecs++;
      if (cfg_err !== 1'b0) begin
        errs++;
        $display("FAIL illegal_err_clear: inc %0d cfg_err=%0b, required 0", bad[k], cfg_err);
      end
    end
    en = 1'b1;
    step();
    step();
    step();
    vecs++;
    if (busy !== 1'b0) begin
      errs++;
      $display("FAIL illegal_no_run: busy=%0b, required 0", busy);
    end
    // Upper legal bound is accepted and starts the run one cycle later
    load(8'd128);
    step();
    vecs++;
    if (busy !== 1'b1) begin
      errs++;
      $display("FAIL legal_max_run: busy=%0b, required 1", busy);
    end
    en = 1'b0;
  endtask

  task automatic test_switch();
    do_reset();
    load(8'd64);
    start_run();
    exp_q.push_back(4);
    exp_q.push_back(4);
    exp_q.push_back(2);
    exp_q.push_back(2);
    exp_q.push_back(2);
    run_cycles(5);
    cfg_valid = 1'b1;
    cfg_inc   = 8'd128;
    run_cycles(1);
    cfg_valid = 1'b0;
    vecs++;
    if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
      errs++;
      $display("FAIL switch_pend_ready: ready=%0b err=%0b, required 0 0", cfg_ready, cfg_err);
    end
    run_cycles(1);
    vecs++;
    if (cfg_ready !== 1'b0) begin
      errs++;
      $display("FAIL switch_hold_ready: ready=%0b, required 0", cfg_ready);
    end
    run_cycles(1);
    vecs++;
    if (cfg_ready !== 1'b1 || tick !== 1'b1) begin
      errs++;
      $display("FAIL switch_apply: ready=%0b tick=%0b, required 1 1", cfg_ready, tick);
    end
    run_cycles(6);
    vecs++;
    if (ntick !== 5 || exp_q.size() != 0) begin
      errs++;
      $display("FAIL switch_count: ticks=%0d left=%0d, required 5 0", ntick, exp_q.size());
    end
    en = 1'b0;
  endtask

  task automatic test_stop();
    int n;
    bit found;
    do_reset();
    load(8'd32);
    start_run();
    exp_q.push_back(8);
    run_cycles(8);
    run_cycles(1);
    en = 1'b0;
    exp_q.push_back(8);
    found = 1'b0;
    n = 0;
    for (int i = 1; i <= 20 && !found; i++) begin
      if (i == 3) en = 1'b1;
      if (i == 4) en = 1'b0;
      run_cycles(1);
      if (tick === 1'b1) begin
        found = 1'b1;
        n = i;
      end
    end
    vecs++;
    if (!found || n != 7) begin
      errs++;
      $display("FAIL stop_drain: final tick after %0d cycles (found=%0b), required 7", n, found);
    end
    vecs++;
    if (busy !== 1'b0 || clk_out !== 1'b0 || cfg_ready !== 1'b1 || period_cnt !== 16'd2) begin
      errs++;
      $display("FAIL stop_idle: busy=%0b clk_out=%0b ready=%0b cnt=%0d, required 0 0 1 2",
               busy, clk_out, cfg_ready, period_cnt);
    end
    run_cycles(5);
    vecs++;
    if (busy !== 1'b0 || clk_out !== 1'b0) begin
      errs++;
      $display("FAIL stop_stays_idle: busy=%0b clk_out=%0b, required 0 0", busy, clk_out);
    end
    // Relaunch from acc=0 gives a full first period
    start_run();
    exp_q.push_back(8);
    run_cycles(8);
    vecs++;
    if (ntick !== 1 || period_cnt !== 16'd1) begin
      errs++;
      $display("FAIL stop_relaunch: ticks=%0d cnt=%0d, required 1 1", ntick, period_cnt);
    end
    en = 1'b0;
  endtask

  task automatic test_reset_mid_run();
    int bad_cycles;
    do_reset();
    load(8'd64);
    start_run();
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vecs++;
    if ({busy, clk_out, tick, cfg_err, cfg_ready} !== 5'b00001 || period_cnt !== 16'd0) begin
      errs++;
      $display("FAIL midrun_reset: busy/clk_out/tick/err/ready=%b cnt=%0d, required 00001 cnt=0",
               {busy, clk_out, tick, cfg_err, cfg_ready}, period_cnt);
    end
    bad_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (busy !== 1'b0 || tick !== 1'b0 || clk_out !== 1'b0) bad_cycles++;
    end
    vecs++;
    if (bad_cycles != 0) begin
      errs++;
      $display("FAIL midrun_stays_idle: %0d active cycles, required 0", bad_cycles);
    end
    en = 1'b0;
  endtask

  initial begin
    vecs = 0;
    errs = 0;
    cyc = 0;
    last_tick = 0;
    ntick = 0;
    highs = 0;
    rst = 1'b1;
    en = 1'b0;
    cfg_valid = 1'b0;
    cfg_inc = '0;
    test_reset();
    test_inc64();
    test_inc96();
    test_illegal();
    test_switch();
    test_stop();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
